// File: rtl/bullet_scheduler.sv
// Shared bullet pool for two tanks: shot arbitration, per-frame motion, pixel hit.
// Ports: Clk/Reset, frame_clk, shoot_req, tank pos/dir, DrawX/Y -> is_bullet, owner, acks, count, busy.
module bullet_scheduler #(
  parameter int         NUM_BULLETS = 4,
  parameter logic [9:0] BULLET_STEP = 10'd4,
  parameter logic [3:0] COOLDOWN    = 4'd8,
  parameter logic [9:0] TANK_W      = 10'd50,
  parameter logic [9:0] TANK_H      = 10'd50,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] Y_MAX       = 10'd479,
  parameter logic [9:0] B_SIZE      = 10'd3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [1:0] shoot_req,
  input  logic [9:0] tank0_X,
  input  logic [9:0] tank0_Y,
  input  logic [9:0] tank1_X,
  input  logic [9:0] tank1_Y,
  input  logic [1:0] tank0_dir,
  input  logic [1:0] tank1_dir,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_bullet,
  output logic       bullet_owner,
  output logic [1:0] fire_ack,
  output logic [1:0] fire_drop,
  output logic [3:0] active_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECAY, S_MOVE,
    S_SPAWN_A, S_SPAWN_B, S_DONE
  } state_t;

  typedef struct packed {
    logic       act;
    logic       own;
    logic [1:0] dir;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  state_t          state_q, state_d;
  slot_t           slot_q [NUM_BULLETS];
  slot_t           slot_d [NUM_BULLETS];
  logic [1:0][3:0] cool_q, cool_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0]      shoot_q;
  logic            frame_q;
  logic            fpend_q, fpend_d;
  logic            rr_q, rr_d;
  logic            gnt_a_q, gnt_a_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;

  logic       t_sel;
  logic       has_free;
  logic       can_grant;
  slot_t      new_slot;
  logic [1:0] sh_rise;
  logic       fr_rise;

  assign sh_rise = shoot_req & ~shoot_q;
  assign fr_rise = frame_clk & ~frame_q;

  // SPAWN_A serves the round-robin tank, SPAWN_B the other one
  assign t_sel = (state_q == S_SPAWN_A) ? rr_q : ~rr_q;

  always_comb begin
    has_free = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++)
      if (!slot_q[i].act) has_free = 1'b1;
  end

  assign can_grant = pend_q[t_sel] &&
                     (cool_q[t_sel] == 4'd0) &&
                     has_free;

  always_comb begin
    new_slot.act = 1'b1;
    new_slot.own = t_sel;
    new_slot.dir = t_sel ? tank1_dir : tank0_dir;
    new_slot.x   = (t_sel ? tank1_X : tank0_X)
                   + (TANK_W >> 1);
    new_slot.y   = (t_sel ? tank1_Y : tank0_Y)
                   + (TANK_H >> 1);
  end

  // 11-bit compares so that edge tests cannot wrap
  function automatic slot_t move_slot(slot_t s);
    slot_t r;
    r = s;
    unique case (s.dir)
      2'd0:
        if (s.y < BULLET_STEP) r.act = 1'b0;
        else r.y = s.y - BULLET_STEP;
      2'd1:
        if ({1'b0, s.y} + {1'b0, BULLET_STEP}
            > {1'b0, Y_MAX}) r.act = 1'b0;
        else r.y = s.y + BULLET_STEP;
      2'd2:
        if (s.x < BULLET_STEP) r.act = 1'b0;
        else r.x = s.x - BULLET_STEP;
      default:
        if ({1'b0, s.x} + {1'b0, BULLET_STEP}
            > {1'b0, X_MAX}) r.act = 1'b0;
        else r.x = s.x + BULLET_STEP;
    endcase
    return r;
  endfunction

  always_comb begin
    logic placed;
    state_d   = state_q;
    slot_d    = slot_q;
    cool_d    = cool_q;
    pend_d    = pend_q;
    fpend_d   = fpend_q;
    rr_d      = rr_q;
    gnt_a_d   = gnt_a_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fire_ack  = 2'b00;
    fire_drop = 2'b00;
    placed    = 1'b0;

    unique case (state_q)
      S_IDLE:
        if (fpend_q) begin
          state_d = S_DECAY;
          fpend_d = 1'b0;
        end
      S_DECAY: begin
        for (int t = 0; t < 2; t++)
          if (cool_q[t] != 4'd0)
            cool_d[t] = cool_q[t] - 4'd1;
        idx_d   = 3'd0;
        gnt_a_d = 1'b0;
        state_d = S_MOVE;
      end
      S_MOVE: begin
        for (int i = 0; i < NUM_BULLETS; i++)
          if (idx_q == 3'(i) && slot_q[i].act)
            slot_d[i] = move_slot(slot_q[i]);
        if (idx_q == 3'(NUM_BULLETS - 1))
          state_d = S_SPAWN_A;
        else
          idx_d = idx_q + 3'd1;
      end
      S_SPAWN_A, S_SPAWN_B: begin
        if (pend_q[t_sel]) begin
          pend_d[t_sel] = 1'b0;
          if (can_grant) begin
            fire_ack[t_sel] = 1'b1;
            cool_d[t_sel]   = COOLDOWN;
            for (int i = 0; i < NUM_BULLETS; i++)
              if (!placed && !slot_q[i].act) begin
                slot_d[i] = new_slot;
                placed    = 1'b1;
              end
          end else begin
            fire_drop[t_sel] = 1'b1;
          end
        end
        if (state_q == S_SPAWN_A) begin
          gnt_a_d = can_grant;
          state_d = S_SPAWN_B;
        end else begin
          rr_d    = rr_q ^ gnt_a_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d = 4'd0;
        for (int i = 0; i < NUM_BULLETS; i++)
          cnt_d = cnt_d + 4'(slot_q[i].act);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a fresh edge always wins over the clear
    pend_d  = pend_d | sh_rise;
    fpend_d = fpend_d | fr_rise;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_BULLETS; i++)
        slot_q[i] <= '0;
      cool_q  <= '0;
      pend_q  <= '0;
      shoot_q <= '0;
      frame_q <= 1'b0;
      fpend_q <= 1'b0;
      rr_q    <= 1'b0;
      gnt_a_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_BULLETS; i++)
        slot_q[i] <= slot_d[i];
      cool_q  <= cool_d;
      pend_q  <= pend_d;
      shoot_q <= shoot_req;
      frame_q <= frame_clk;
      fpend_q <= fpend_d;
      rr_q    <= rr_d;
      gnt_a_q <= gnt_a_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign active_count = cnt_q;
  assign busy         = (state_q != S_IDLE);

  // lowest-index hit owns the pixel, so scan high to low
  always_comb begin
    logic signed [10:0] dx, dy, bs;
    is_bullet    = 1'b0;
    bullet_owner = 1'b0;
    dx = '0;
    dy = '0;
    bs = $signed({1'b0, B_SIZE});
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      dx = $signed({1'b0, DrawX})
           - $signed({1'b0, slot_q[i].x});
      dy = $signed({1'b0, DrawY})
           - $signed({1'b0, slot_q[i].y});
      if (slot_q[i].act &&
          dx >= 0 && dx <= bs &&
          dy >= 0 && dy <= bs) begin
        is_bullet    = 1'b1;
        bullet_owner = slot_q[i].own;
      end
    end
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: spawn, motion, cooldown,
// round-robin, pool exhaustion, slot reuse and asynchronous reset.
module tb_bullet_scheduler;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [1:0] shoot_req;
  logic [9:0] tank0_X, tank0_Y;
  logic [9:0] tank1_X, tank1_Y;
  logic [1:0] tank0_dir, tank1_dir;
  logic [9:0] DrawX, DrawY;
  logic       is_bullet;
  logic       bullet_owner;
  logic [1:0] fire_ack;
  logic [1:0] fire_drop;
  logic [3:0] active_count;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] aa, da, ab, db;
  int         nb;

  bullet_scheduler dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .shoot_req    (shoot_req),
    .tank0_X      (tank0_X),
    .tank0_Y      (tank0_Y),
    .tank1_X      (tank1_X),
    .tank1_Y      (tank1_Y),
    .tank0_dir    (tank0_dir),
    .tank1_dir    (tank1_dir),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .is_bullet    (is_bullet),
    .bullet_owner (bullet_owner),
    .fire_ack     (fire_ack),
    .fire_drop    (fire_drop),
    .active_count (active_count),
    .busy         (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag,
                     input logic [9:0] x,
                     input logic [9:0] y,
                     input logic hit,
                     input logic own);
    DrawX = x;
    DrawY = y;
    #1;
    chk({tag, "_hit"}, 32'(is_bullet), 32'(hit));
    chk({tag, "_own"}, 32'(bullet_owner), 32'(own));
  endtask

  task automatic shoot(input logic [1:0] p);
    shoot_req = p;
    cyc(1);
    shoot_req = 2'b00;
    cyc(1);
  endtask

  // k counts posedges after frame_clk rises:
  // 2 DECAY, 3..6 MOVE, 7 SPAWN_A, 8 SPAWN_B, 9 DONE
  task automatic tick(output logic [1:0] o_aa,
                      output logic [1:0] o_da,
                      output logic [1:0] o_ab,
                      output logic [1:0] o_db,
                      output int o_nb);
    o_aa = 'x; o_da = 'x;
    o_ab = 'x; o_db = 'x;
    o_nb = 0;
    frame_clk = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (k == 1) frame_clk = 1'b0;
      if (busy) o_nb++;
      if (k == 7) begin
        o_aa = fire_ack;
        o_da = fire_drop;
      end
      if (k == 8) begin
        o_ab = fire_ack;
        o_db = fire_drop;
      end
    end
  endtask

  task automatic do_reset;
    Reset = 1'b0;
    cyc(3);
    chk("rst_cnt", 32'(active_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(fire_ack), 0);
    chk("rst_drop", 32'(fire_drop), 0);
    Reset = 1'b1;
    cyc(1);
  endtask

  initial begin
    Reset     = 1'b0;
    frame_clk = 1'b0;
    shoot_req = 2'b00;
    DrawX     = 10'd0;
    DrawY     = 10'd0;
    tank0_X   = 10'd100;
    tank0_Y   = 10'd200;
    tank0_dir = 2'd3;
    tank1_X   = 10'd300;
    tank1_Y   = 10'd100;
    tank1_dir = 2'd1;

    // phase 1: single rightward shot
    do_reset();
    pix("rst_pix", 10'd125, 10'd225, 1'b0, 1'b0);

    tick(aa, da, ab, db, nb);
    chk("idle_busy_len", 32'(nb), 8);
    chk("idle_ack_a", 32'(aa), 0);
    chk("idle_drop_b", 32'(db), 0);

    shoot(2'b01);
    tick(aa, da, ab, db, nb);
    chk("p1_ack_a", 32'(aa), 32'b01);
    chk("p1_ack_b", 32'(ab), 0);
    chk("p1_drop_b", 32'(db), 0);
    chk("p1_cnt", 32'(active_count), 1);
    pix("p1_spawn", 10'd127, 10'd226, 1'b1, 1'b0);

    tick(aa, da, ab, db, nb);
    pix("p1_mv_l", 10'd129, 10'd225, 1'b1, 1'b0);
    pix("p1_mv_out", 10'd128, 10'd225, 1'b0, 1'b0);
    pix("p1_mv_br", 10'd132, 10'd228, 1'b1, 1'b0);
    pix("p1_mv_br1", 10'd133, 10'd228, 1'b0, 1'b0);

    // phase 2: arbitration, cooldown, full pool, reuse
    do_reset();
    tank0_X   = 10'd0;
    tank0_Y   = 10'd41;
    tank0_dir = 2'd0;

    shoot(2'b11);
    tick(aa, da, ab, db, nb);
    chk("t1_ack_a", 32'(aa), 32'b01);
    chk("t1_ack_b", 32'(ab), 32'b10);
    chk("t1_cnt", 32'(active_count), 2);
    pix("t1_s0", 10'd25, 10'd66, 1'b1, 1'b0);
    pix("t1_s1", 10'd325, 10'd125, 1'b1, 1'b1);
    pix("t1_s0c", 10'd28, 10'd69, 1'b1, 1'b0);
    pix("t1_s0x", 10'd29, 10'd66, 1'b0, 1'b0);

    tick(aa, da, ab, db, nb);
    pix("t2_up", 10'd25, 10'd62, 1'b1, 1'b0);
    pix("t2_up_x", 10'd25, 10'd61, 1'b0, 1'b0);

    tick(aa, da, ab, db, nb);
    shoot(2'b01);
    tick(aa, da, ab, db, nb);
    chk("t4_ack_a", 32'(aa), 0);
    chk("t4_drop_a", 32'(da), 0);
    chk("t4_ack_b", 32'(ab), 0);
    chk("t4_drop_b", 32'(db), 32'b01);
    chk("t4_cnt", 32'(active_count), 2);

    for (int t = 5; t <= 8; t++)
      tick(aa, da, ab, db, nb);

    shoot(2'b11);
    tick(aa, da, ab, db, nb);
    chk("t9_ack_a", 32'(aa), 32'b10);
    chk("t9_ack_b", 32'(ab), 32'b01);
    chk("t9_cnt", 32'(active_count), 4);
    pix("t9_s2", 10'd326, 10'd126, 1'b1, 1'b1);
    pix("t9_s0", 10'd25, 10'd34, 1'b1, 1'b0);

    for (int t = 10; t <= 16; t++)
      tick(aa, da, ab, db, nb);

    shoot(2'b11);
    tick(aa, da, ab, db, nb);
    chk("t17_drop_a", 32'(da), 32'b01);
    chk("t17_drop_b", 32'(db), 32'b10);
    chk("t17_ack_a", 32'(aa), 0);
    chk("t17_ack_b", 32'(ab), 0);
    chk("t17_cnt", 32'(active_count), 4);

    shoot(2'b11);
    tick(aa, da, ab, db, nb);
    chk("t18_ack_a", 32'(aa), 32'b01);
    chk("t18_drop_b", 32'(db), 32'b10);
    chk("t18_cnt", 32'(active_count), 4);
    pix("t18_reuse", 10'd25, 10'd66, 1'b1, 1'b0);
    pix("t18_gone", 10'd25, 10'd2, 1'b0, 1'b0);

    // reset in the middle of MOVE
    frame_clk = 1'b1;
    cyc(1);
    frame_clk = 1'b0;
    cyc(3);
    chk("mv_busy", 32'(busy), 1);
    Reset = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_cnt", 32'(active_count), 0);
    pix("mr_pix", 10'd25, 10'd66, 1'b0, 1'b0);
    cyc(2);
    Reset = 1'b1;
    cyc(1);
    tick(aa, da, ab, db, nb);
    chk("post_busy_len", 32'(nb), 8);
    chk("post_cnt", 32'(active_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Owns a shared pool of bullet slots used by both tanks.
- Arbitrates shoot requests between tank 0 and tank 1 with round-robin priority, per-tank cooldown and slot allocation.
- On each frame tick, advances every live bullet and retires out-of-bounds ones, then spawns new bullets.
- Sits between the two tank instances and the colour mapper; provides per-pixel bullet hit output.

Parameters:
- NUM_BULLETS, 4, number of slots in the shared pool (2..8).
- BULLET_STEP, 10'd4, pixels moved per frame.
- COOLDOWN, 4'd8, frames a tank must wait after a granted shot.
- TANK_W, 10'd50, tank width; spawn X offset is TANK_W/2.
- TANK_H, 10'd50, tank height; spawn Y offset is TANK_H/2.
- X_MAX, 10'd639, rightmost legal bullet X.
- Y_MAX, 10'd479, bottommost legal bullet Y.
- B_SIZE, 10'd3, bullet square side minus 1, used for pixel hit.

Ports:
- Clk, input, 1, 50 MHz system clock.
- Reset, input, 1, asynchronous, active-low reset.
- frame_clk, input, 1, ~60 Hz frame indicator; the block detects its rising edge internally.
- shoot_req, input, 2, per-tank shoot level ([0]=tank0, [1]=tank1).
- tank0_X, input, 10, tank 0 top-left X.
- tank0_Y, input, 10, tank 0 top-left Y.
- tank1_X, input, 10, tank 1 top-left X.
- tank1_Y, input, 10, tank 1 top-left Y.
- tank0_dir, input, 2, tank 0 facing direction: 0=up, 1=down, 2=left, 3=right.
- tank1_dir, input, 2, tank 1 facing direction, same encoding.
- DrawX, input, 10, current pixel X.
- DrawY, input, 10, current pixel Y.
- is_bullet, output, 1, current pixel lies in a live bullet.
- bullet_owner, output, 1, owner of the lowest-index bullet hit at this pixel.
- fire_ack, output, 2, one-cycle pulse per tank when its shot is granted.
- fire_drop, output, 2, one-cycle pulse per tank when its shot is discarded.
- active_count, output, 4, number of live slots.
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, Reset=0):
  - All slots inactive; cooldowns 0; pending 0; rr pointer selects tank0.
  - FSM in IDLE.
  - fire_ack, fire_drop, active_count, busy all 0; is_bullet and bullet_owner 0.
- Request capture:
  - shoot_req is edge-detected per tank on Clk; a rising edge sets pending[t].
  - A held level does not retrigger.
  - A new edge while pending[t] is already set is absorbed.
- Frame tick:
  - Rising edge of frame_clk sets frame_pend; IDLE moves to DECAY when frame_pend=1.
  - frame_pend clears on entering DECAY.
  - An edge arriving while busy re-sets frame_pend and is serviced after DONE; at most one tick is queued.
- FSM states:
  - IDLE.
  - DECAY (1 cycle): each nonzero cooldown decrements by 1.
  - MOVE (NUM_BULLETS cycles): slot i is processed on cycle i.
  - SPAWN_A (1 cycle): serves the rr-priority tank.
  - SPAWN_B (1 cycle): serves the other tank.
  - DONE (1 cycle): returns to IDLE.
  - Total busy time is NUM_BULLETS+4 cycles.
- MOVE, per live slot, by direction:
  - up: if Y < BULLET_STEP, retire, else Y -= BULLET_STEP.
  - down: if Y + BULLET_STEP > Y_MAX, retire, else Y += BULLET_STEP.
  - left and right: same rules on X against 0 and X_MAX.
  - Compare in 11-bit to avoid unsigned wrap.
- SPAWN_x for tank t, only if pending[t]=1:
  - Grant when cooldown[t]=0 and a free slot exists: the lowest-index free slot is loaded with active=1, owner=t, dir=tank_dir, X=tank_X+TANK_W/2, Y=tank_Y+TANK_H/2 (tank inputs sampled this cycle). cooldown[t] loads COOLDOWN, fire_ack[t] pulses, pending[t] clears.
  - Otherwise fire_drop[t] pulses and pending[t] clears.
  - A slot freed in MOVE of the same tick is reusable.
  - A slot granted in SPAWN_A is not free in SPAWN_B.
- rr pointer: toggles after SPAWN_B if the priority tank was granted; otherwise unchanged.
- active_count is registered and updated at DONE.
- Pixel output is combinational:
  - Slot i hits when active and 0 ≤ DrawX−X ≤ B_SIZE and 0 ≤ DrawY−Y ≤ B_SIZE (signed compare).
  - is_bullet is the OR of all hits; bullet_owner comes from the lowest-index hit.
- Newly spawned bullets do not move until the next tick.

Test Plan:
- Reset low for 3 cycles, then high → active_count=0, is_bullet=0, busy=0; a frame tick gives busy high for exactly 8 cycles (NUM_BULLETS=4).
- Tank0 at (100,200), dir=3, shoot pulse, one tick → fire_ack[0] in SPAWN_A, slot0 at (125,225); next tick → X=129; pixel (127,226) gives is_bullet=1, owner=0.
- Both tanks request on the same tick, 4 slots free, rr=tank0 → tank0 gets slot0 and tank1 gets slot1; rr then points to tank1.
- Repeat the request 3 ticks after a grant with COOLDOWN=8 → fire_drop pulses, no new slot; request at tick 9 → granted.
- Bullet dir=0 at Y=2 → retired on the next tick, active_count decrements, slot reusable in the same tick's SPAWN.
- All 4 slots full, both tanks request → both fire_drop; Reset asserted mid-MOVE → all slots cleared immediately, FSM in IDLE.
